// File: rtl/div2_pkg.sv
// Shared definitions for the program-2 divide engine: FSM states,
// sequencing constants and the default data-memory map.
package div2_pkg;

  // Sequencing lengths of each phase of a run
  localparam int DIV_ITERS    = 24;
  localparam int LOAD_CYCLES  = 4;
  localparam int STORE_CYCLES = 3;

  // Default data-memory map
  localparam int DEF_ADDR_W           = 8;
  localparam int DEF_DIVIDEND_HI_ADDR = 0;
  localparam int DEF_DIVIDEND_LO_ADDR = 1;
  localparam int DEF_DIVISOR_ADDR     = 2;
  localparam int DEF_RESULT_ADDR      = 4;

  // Result reported for a zero divisor
  localparam logic [23:0] SAT_RESULT = 24'hFFFFFF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIV,
    STORE,
    DONE
  } div2_state_e;

endpackage

// File: rtl/div2_engine_seq_div24.sv
// Restoring divider: 24-bit numerator by 8-bit divisor, one quotient bit
// per clock, MSB first. The quotient shifts into the numerator register as
// the numerator bits shift out, so a single 24-bit register holds both.
module seq_div24
  import div2_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] numerator,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [23:0] quotient
);

  logic [23:0] num_q;
  logic [7:0]  rem_q;
  logic [7:0]  div_q;
  logic [4:0]  iter_q;

  logic [8:0]  rem_shift;
  logic        q_bit;
  logic [7:0]  rem_next;

  // One restoring step: shift in the next numerator bit, subtract if it fits
  always_comb begin
    rem_shift = {rem_q, num_q[23]};
    q_bit     = (rem_shift >= {1'b0, div_q});
    rem_next  = q_bit ? 8'(rem_shift - {1'b0, div_q}) : rem_shift[7:0];
  end

  // Operand capture on start, then DIV_ITERS iterations with a done pulse on the last
  always_ff @(posedge clk) begin
    if (reset) begin
      num_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      iter_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        num_q  <= numerator;
        rem_q  <= '0;
        div_q  <= divisor;
        iter_q <= '0;
        busy   <= 1'b1;
      end else if (busy) begin
        num_q  <= {num_q[22:0], q_bit};
        rem_q  <= rem_next;
        iter_q <= iter_q + 5'd1;
        if (iter_q == 5'(DIV_ITERS - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = num_q;

endmodule

// File: rtl/div2_engine.sv
// Program-2 divide engine: on a Start high->low it reads the dividend and
// divisor from data memory, divides (dividend << 8) by the divisor and writes
// the 24-bit quotient back, then raises Ack until Start goes high again.
// All memory-side outputs are registered; the launch edge is E0 and Ack rises
// exactly 32 edges later.
module div2_engine
  import div2_pkg::*;
#(
  parameter int ADDR_W           = DEF_ADDR_W,
  parameter int DIVIDEND_HI_ADDR = DEF_DIVIDEND_HI_ADDR,
  parameter int DIVIDEND_LO_ADDR = DEF_DIVIDEND_LO_ADDR,
  parameter int DIVISOR_ADDR     = DEF_DIVISOR_ADDR,
  parameter int RESULT_ADDR      = DEF_RESULT_ADDR
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Ack,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [7:0]        MemRdData,
  output logic              MemWrEn,
  output logic [7:0]        MemWrData
);

  localparam logic [ADDR_W-1:0] HI_A   = ADDR_W'(DIVIDEND_HI_ADDR);
  localparam logic [ADDR_W-1:0] LO_A   = ADDR_W'(DIVIDEND_LO_ADDR);
  localparam logic [ADDR_W-1:0] DVS_A  = ADDR_W'(DIVISOR_ADDR);
  localparam logic [ADDR_W-1:0] RES0_A = ADDR_W'(RESULT_ADDR);
  localparam logic [ADDR_W-1:0] RES1_A = ADDR_W'(RESULT_ADDR + 1);
  localparam logic [ADDR_W-1:0] RES2_A = ADDR_W'(RESULT_ADDR + 2);

  div2_state_e state_q, state_d;

  logic [1:0]        load_cnt_q, load_cnt_d;
  logic [1:0]        store_cnt_q, store_cnt_d;
  logic              start_prev_q;
  logic [7:0]        dividend_hi_q, dividend_hi_d;
  logic [7:0]        dividend_lo_q, dividend_lo_d;
  logic [7:0]        divisor_q, divisor_d;
  logic [ADDR_W-1:0] addr_d;
  logic              wr_en_d;
  logic [7:0]        wr_data_d;
  logic              ack_d;

  logic              div_start;
  logic              div_busy;
  logic              div_done;
  logic [23:0]       numerator;
  logic [23:0]       quotient;
  logic [23:0]       result;

  assign numerator = {dividend_hi_q, dividend_lo_q, 8'h00};
  assign result    = (divisor_q == 8'd0) ? SAT_RESULT : quotient;

  seq_div24 u_div (
    .clk       (Clk),
    .reset     (Reset),
    .start     (div_start),
    .numerator (numerator),
    .divisor   (MemRdData),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (quotient)
  );

  // Next-state and next registered-output decode for the run sequence
  always_comb begin
    state_d       = state_q;
    load_cnt_d    = load_cnt_q;
    store_cnt_d   = store_cnt_q;
    dividend_hi_d = dividend_hi_q;
    dividend_lo_d = dividend_lo_q;
    divisor_d     = divisor_q;
    addr_d        = '0;
    wr_en_d       = 1'b0;
    wr_data_d     = 8'h00;
    ack_d         = 1'b0;
    div_start     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!Start && start_prev_q) begin
          state_d    = LOAD;
          load_cnt_d = 2'd0;
          addr_d     = HI_A;
        end
      end

      LOAD: begin
        if (load_cnt_q == 2'd0) begin
          addr_d     = LO_A;
          load_cnt_d = 2'd1;
        end else if (load_cnt_q == 2'd1) begin
          addr_d        = DVS_A;
          dividend_hi_d = MemRdData;
          load_cnt_d    = 2'd2;
        end else if (load_cnt_q == 2'd2) begin
          dividend_lo_d = MemRdData;
          load_cnt_d    = 2'd3;
        end else if (load_cnt_q == 2'(LOAD_CYCLES - 1)) begin
          divisor_d = MemRdData;
          div_start = 1'b1;
          state_d   = DIV;
        end
      end

      DIV: begin
        if (div_done && !div_busy) begin
          state_d     = STORE;
          store_cnt_d = 2'd0;
          addr_d      = RES0_A;
          wr_en_d     = 1'b1;
          wr_data_d   = result[23:16];
        end
      end

      STORE: begin
        if (store_cnt_q == 2'd0) begin
          addr_d      = RES1_A;
          wr_en_d     = 1'b1;
          wr_data_d   = result[15:8];
          store_cnt_d = 2'd1;
        end else if (store_cnt_q == 2'd1) begin
          addr_d      = RES2_A;
          wr_en_d     = 1'b1;
          wr_data_d   = result[7:0];
          store_cnt_d = 2'd2;
        end else if (store_cnt_q == 2'(STORE_CYCLES - 1)) begin
          state_d = DONE;
          ack_d   = 1'b1;
        end
      end

      DONE: begin
        if (Start) begin
          state_d = IDLE;
        end else begin
          ack_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset abandons any run in progress
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, captured operands, Start history and the registered memory/handshake outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      load_cnt_q    <= '0;
      store_cnt_q   <= '0;
      start_prev_q  <= 1'b0;
      dividend_hi_q <= '0;
      dividend_lo_q <= '0;
      divisor_q     <= '0;
      MemAddr       <= '0;
      MemWrEn       <= 1'b0;
      MemWrData     <= '0;
      Ack           <= 1'b0;
    end else begin
      load_cnt_q    <= load_cnt_d;
      store_cnt_q   <= store_cnt_d;
      start_prev_q  <= Start;
      dividend_hi_q <= dividend_hi_d;
      dividend_lo_q <= dividend_lo_d;
      divisor_q     <= divisor_d;
      MemAddr       <= addr_d;
      MemWrEn       <= wr_en_d;
      MemWrData     <= wr_data_d;
      Ack           <= ack_d;
    end
  end

endmodule

// File: tb/tb_div2_engine.sv
// Bench for div2_engine: byte-wide synchronous-read memory model, table of
// directed operand sets, hand-written reset/back-to-back sequences and
// randomized runs checked against an arithmetic quotient model.
module tb_div2_engine;

  localparam int RES = 4;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Ack;
  logic [7:0] MemAddr;
  logic [7:0] MemRdData;
  logic       MemWrEn;
  logic [7:0] MemWrData;

  logic [7:0] mem [256];
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr = 8'h00;
  logic [7:0] pl_data = 8'h00;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int bad_wr = 0;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [7:0]  dv;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[6];

  div2_engine dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Ack       (Ack),
    .MemAddr   (MemAddr),
    .MemRdData (MemRdData),
    .MemWrEn   (MemWrEn),
    .MemWrData (MemWrData)
  );

  always #5 Clk = ~Clk;

  // Data memory: one-cycle read latency, DUT writes, bench preload port
  always @(posedge Clk) begin
    MemRdData <= mem[MemAddr];
    if (MemWrEn) mem[MemAddr] <= MemWrData;
    else if (pl_en) mem[pl_addr] <= pl_data;
  end

  // Count DUT write strobes and flag any outside the result bytes
  always @(posedge Clk) begin
    if (MemWrEn) begin
      wr_count = wr_count + 1;
      if (MemAddr < 8'(RES) || MemAddr > 8'(RES + 2)) bad_wr = bad_wr + 1;
    end
  end

  function automatic logic [23:0] refQuot(input logic [15:0] dividend, input logic [7:0] dv);
    longint n;
    if (dv == 8'd0) return 24'hFFFFFF;
    n = longint'(dividend) * 256;
    return 24'(n / longint'(dv));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pokeMem(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge Clk);
    pl_en = 1'b0;
  endtask

  task automatic loadOperands(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] dv);
    pokeMem(8'd0, hi);
    pokeMem(8'd1, lo);
    pokeMem(8'd2, dv);
    pokeMem(8'(RES), 8'hA5);
    pokeMem(8'(RES + 1), 8'hA5);
    pokeMem(8'(RES + 2), 8'hA5);
    wr_count = 0;
    bad_wr = 0;
  endtask

  // Load operands, launch with a Start 1->0 and count edges from E0 to Ack
  task automatic applyStimulus(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] dv,
                               input bit toggle, output int lat);
    @(negedge Clk);
    loadOperands(hi, lo, dv);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    @(posedge Clk);
    lat = 0;
    while (lat < 100) begin
      @(negedge Clk);
      if (Ack) break;
      if (toggle) Start = (lat >= 8 && lat <= 14) ? lat[0] : 1'b0;
      @(posedge Clk);
      lat++;
    end
  endtask

  task automatic checkRun(input string tag, input logic [7:0] hi, input logic [7:0] lo,
                          input logic [7:0] dv, input logic [23:0] exp, input int lat);
    checkOutput({tag, " latency"}, 32'(lat), 32'd32);
    checkOutput({tag, " result"}, 32'({mem[RES], mem[RES + 1], mem[RES + 2]}), 32'(exp));
    checkOutput({tag, " operands"}, 32'({mem[0], mem[1], mem[2]}), 32'({hi, lo, dv}));
    checkOutput({tag, " writes"}, 32'(wr_count * 256 + bad_wr), 32'(3 * 256));
  endtask

  initial begin
    int lat;
    bit ack_seen;
    logic [7:0] hi, lo, dv;

    vecs[0] = '{hi: 8'h01, lo: 8'h81, dv: 8'h06, exp: 24'h00402A};
    vecs[1] = '{hi: 8'h00, lo: 8'h03, dv: 8'hFF, exp: 24'h000003};
    vecs[2] = '{hi: 8'hFF, lo: 8'hFF, dv: 8'h01, exp: 24'hFFFF00};
    vecs[3] = '{hi: 8'hFF, lo: 8'hFF, dv: 8'hFF, exp: 24'h010100};
    vecs[4] = '{hi: 8'h12, lo: 8'h34, dv: 8'h00, exp: 24'hFFFFFF};
    vecs[5] = '{hi: 8'h00, lo: 8'h00, dv: 8'h07, exp: 24'h000000};

    Reset = 1'b1;
    Start = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checkOutput("reset Ack", 32'(Ack), 32'd0);
    checkOutput("reset MemWrEn", 32'(MemWrEn), 32'd0);
    checkOutput("reset MemAddr", 32'(MemAddr), 32'd0);
    checkOutput("reset MemWrData", 32'(MemWrData), 32'd0);
    Reset = 1'b0;

    ack_seen = 1'b0;
    repeat (40) begin
      @(negedge Clk);
      if (Ack) ack_seen = 1'b1;
    end
    checkOutput("no launch from low Start", 32'({ack_seen, 8'(wr_count)}), 32'd0);

    $display("[TB] directed table");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].hi, vecs[i].lo, vecs[i].dv, 1'b0, lat);
      checkRun($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo, vecs[i].dv, vecs[i].exp, lat);
    end

    $display("[TB] reset during divide");
    @(negedge Clk);
    loadOperands(8'h01, 8'h81, 8'h06);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    @(posedge Clk);
    repeat (9) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    checkOutput("abort outputs", 32'({Ack, MemWrEn, MemAddr}), 32'd0);
    ack_seen = 1'b0;
    repeat (40) begin
      @(negedge Clk);
      if (Ack) ack_seen = 1'b1;
    end
    checkOutput("abort no Ack", 32'(ack_seen), 32'd0);
    checkOutput("abort no writes", 32'(wr_count), 32'd0);
    checkOutput("abort result untouched", 32'({mem[RES], mem[RES + 1], mem[RES + 2]}), 32'h00A5A5A5);
    applyStimulus(8'h01, 8'h81, 8'h06, 1'b0, lat);
    checkRun("after abort", 8'h01, 8'h81, 8'h06, 24'h00402A, lat);

    $display("[TB] back-to-back with Start toggles");
    ack_seen = 1'b1;
    repeat (5) begin
      @(negedge Clk);
      if (!Ack) ack_seen = 1'b0;
    end
    checkOutput("Ack held", 32'(ack_seen), 32'd1);
    Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    checkOutput("Ack cleared by Start", 32'(Ack), 32'd0);
    applyStimulus(8'hBE, 8'hEF, 8'h2D, 1'b1, lat);
    checkRun("toggled", 8'hBE, 8'hEF, 8'h2D, refQuot(16'hBEEF, 8'h2D), lat);

    $display("[TB] random runs");
    for (int i = 0; i < 16; i++) begin
      hi = 8'($urandom_range(0, 255));
      lo = 8'($urandom_range(0, 255));
      dv = (i % 5 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      applyStimulus(hi, lo, dv, (i % 3 == 0), lat);
      checkRun($sformatf("rand%0d", i), hi, lo, dv, refQuot({hi, lo}, dv), lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
